demux_burst_dispatcher: RTL and testbench

//   Sequencer and round-robin scheduler for a 1-to-N_OUT demultiplexer datapath.

---
 rtl/demux_burst_dispatcher.sv | 120 ++++++++++++
 tb/tb_demux_burst_dispatcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_burst_dispatcher.sv
// Round-robin burst scheduler for a 1-to-N_OUT demux: grants one enabled channel,
// holds it for BURST_LEN accepted beats, then rotates the search pointer past it.
module demux_burst_dispatcher #(
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_OUT-1:0]  en_mask,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              burst_done
);

  localparam int unsigned      CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_OUT - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               grant_found;
  logic [SEL_W-1:0]   grant_idx;
  logic               beat;

  // Circular priority scan starting at ptr_q; wrap is an explicit compare so
  // non-power-of-two channel counts never land on a nonexistent channel.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    idx         = ptr_q;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (!grant_found && en_mask[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
      idx = (idx == LAST_CH) ? '0 : idx + 1'b1;
    end
  end

  assign beat = (state_q == BURST) && in_valid && out_ready[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && grant_found) begin
          sel_d   = grant_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            ptr_d   = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs depend only on registered state plus the opposite-side handshake,
  // so out_ready never reaches out_valid and in_valid never reaches in_ready.
  always_comb begin
    out_valid = '0;
    in_ready  = 1'b0;
    if (state_q == BURST) begin
      out_valid = (N_OUT'(1) << sel_q) & {N_OUT{in_valid}};
      in_ready  = out_ready[sel_q];
    end
  end

  assign out_data   = in_data;
  assign sel        = sel_q;
  assign busy       = (state_q == BURST);
  assign burst_done = done_q;

endmodule

// File: tb/tb_demux_burst_dispatcher.sv
// Scoreboard bench for demux_burst_dispatcher: expected (channel, data) pairs are
// queued as bursts are driven and popped as beats are accepted.
module tb_demux_burst_dispatcher;

  localparam int unsigned N_OUT     = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_OUT-1:0]  en_mask;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              burst_done;

  always #5 clk = ~clk;

  demux_burst_dispatcher #(
    .N_OUT    (N_OUT),
    .SEL_W    (SEL_W),
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .burst_done(burst_done)
  );

  typedef struct {
    int          ch;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   m_ptr    = 0;
  int   done_cnt = 0;
  int   beat_cnt = 0;
  bit   watch_02 = 1'b0;
  int   bad_02   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] mask, input int ptr);
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (ptr + i) % 4;
      if (mask[c[1:0]]) return c;
    end
    return -1;
  endfunction

  exp_t e;
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check_eq("beat_out_valid", 32'(out_valid), 32'(1) << e.ch);
        check_eq("beat_sel", 32'(sel), 32'(e.ch));
        check_eq("beat_data", 32'(out_data), 32'(e.data));
      end
      beat_cnt++;
    end
    if (!rst && burst_done) done_cnt++;
    if (watch_02 && (out_valid[0] || out_valid[2])) bad_02++;
  end

  // Drives one burst (or its first nbeats beats) and queues the model's expectation.
  task automatic drive_burst(input logic [3:0] mask, input int nbeats, input logic [7:0] base,
                             input int mid_at, input logic [3:0] mid_mask, output int cycles);
    int g;
    int k;
    bit acc;
    g = model_grant(mask, m_ptr);
    for (int i = 0; i < nbeats; i++) sb.push_back('{g, base + 8'(i)});
    if (nbeats == 4) m_ptr = (g == 3) ? 0 : g + 1;
    en_mask  = mask;
    in_valid = 1'b1;
    cycles   = 0;
    k        = 0;
    while (k < nbeats && cycles < 50) begin
      in_data = base + 8'(k);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (acc) begin
        k++;
        if (k == mid_at) en_mask = mid_mask;
      end
    end
    if (k < nbeats) check_eq("burst_timeout", 32'(k), 32'(nbeats));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int d0;
    int b0;
    rst       = 1'b1;
    en_mask   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '1;

    // 1 reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sel", 32'(sel), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(burst_done), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;

    // 2 round robin, full mask
    d0 = done_cnt;
    for (int b = 0; b < 4; b++) begin
      drive_burst(4'b1111, 4, 8'(8'h20 + b * 16), 0, 4'b1111, cyc);
      check_eq("rr_cycles", 32'(cyc), 32'(5));
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("rr_done_pulses", 32'(done_cnt - d0), 32'(4));

    // 3 sparse mask
    watch_02 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive_burst(4'b1010, 4, 8'(8'h80 + b * 16), 0, 4'b1010, cyc);
      check_eq("sparse_cycles", 32'(cyc), 32'(5));
    end
    watch_02 = 1'b0;
    check_eq("sparse_no_ch0_ch2", 32'(bad_02), 32'(0));

    // 4 backpressure on ch1
    b0 = beat_cnt;
    fork
      drive_burst(4'b0010, 4, 8'h10, 0, 4'b0010, cyc);
      begin
        int t;
        t = 0;
        while (beat_cnt < b0 + 2 && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        check_eq("stall_sync", 32'(beat_cnt - b0), 32'(2));
        out_ready[1] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_in_ready", 32'(in_ready), 32'(0));
          check_eq("stall_beat_cnt", 32'(dut.cnt_q), 32'(2));
          @(posedge clk);
          #1;
        end
        out_ready = '1;
      end
    join
    check_eq("bp_cycles", 32'(cyc), 32'(8));
    check_eq("bp_beats", 32'(beat_cnt - b0), 32'(4));

    // 5 mask change mid-burst
    drive_burst(4'b1111, 4, 8'h30, 2, 4'b0001, cyc);
    check_eq("mask_chg_cycles", 32'(cyc), 32'(5));
    drive_burst(4'b0001, 4, 8'h40, 0, 4'b0001, cyc);
    check_eq("mask_wrap_cycles", 32'(cyc), 32'(5));

    // 6 reset mid-burst
    en_mask = 4'b1111;
    drive_burst(4'b1111, 2, 8'h50, 0, 4'b1111, cyc);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'(0));
    check_eq("midrst_sel", 32'(sel), 32'(0));
    check_eq("midrst_out_valid", 32'(out_valid), 32'(0));
    check_eq("midrst_ptr", 32'(dut.ptr_q), 32'(0));
    @(posedge clk);
    #1;
    d0 = done_cnt;
    drive_burst(4'b1111, 4, 8'h60, 0, 4'b1111, cyc);
    check_eq("post_rst_cycles", 32'(cyc), 32'(5));
    @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("post_rst_done", 32'(done_cnt - d0), 32'(1));

    check_eq("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
